// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative 32-bit MIPS divider.
package div_unit_pkg;

    localparam int DIV_W    = 32;
    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_unit_if;
    import div_unit_pkg::*;

    // A request is accepted on a rising edge where start=1, cancel=0 and busy=0:
    // start is the valid, ~busy the ready. done is a one-cycle valid for
    // quotient/remainder with no back-pressure; the results hold until the next accept.
    logic             start;
    logic             signed_div;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;

    modport master (
        output start, signed_div, dividend, divisor, cancel,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, signed_div, dividend, divisor, cancel,
        output busy, done, quotient, remainder
    );

endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: 32 CALC cycles, one DONE cycle,
// results feed HI (remainder) and LO (quotient).
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus,
    output div_state_e dbg_state
);

    div_state_e       state;
    logic [4:0]       cnt;
    logic [DIV_W-1:0] prem;
    logic [DIV_W-1:0] dsr;
    logic [DIV_W-1:0] dvs;
    logic [DIV_W-1:0] raw_dvd;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic             done_r;
    logic [DIV_W-1:0] quo_r;
    logic [DIV_W-1:0] rem_r;

    logic [DIV_W:0]   shifted;
    logic [DIV_W:0]   trial;
    logic             q_bit;
    logic [DIV_W-1:0] q_next;
    logic [DIV_W-1:0] r_next;
    logic [DIV_W-1:0] q_fix;
    logic [DIV_W-1:0] r_fix;

    // dsr starts as the dividend magnitude and fills with quotient bits from the LSB.
    always_comb begin
        shifted = {prem, dsr[DIV_W-1]};
        trial   = shifted - {1'b0, dvs};
        q_bit   = ~trial[DIV_W];
        q_next  = {dsr[DIV_W-2:0], q_bit};
        r_next  = q_bit ? trial[DIV_W-1:0] : shifted[DIV_W-1:0];
        q_fix   = div0 ? '1      : (neg_q ? (~q_next + 32'd1) : q_next);
        r_fix   = div0 ? raw_dvd : (neg_r ? (~r_next + 32'd1) : r_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            prem    <= '0;
            dsr     <= '0;
            dvs     <= '0;
            raw_dvd <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            done_r  <= 1'b0;
            quo_r   <= '0;
            rem_r   <= '0;
        end else if (bus.cancel) begin
            state  <= DIV_IDLE;
            done_r <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        neg_q   <= bus.signed_div & (bus.dividend[DIV_W-1] ^ bus.divisor[DIV_W-1]);
                        neg_r   <= bus.signed_div & bus.dividend[DIV_W-1];
                        dsr     <= magnitude(bus.dividend, bus.signed_div & bus.dividend[DIV_W-1]);
                        dvs     <= magnitude(bus.divisor, bus.signed_div & bus.divisor[DIV_W-1]);
                        div0    <= (bus.divisor == '0);
                        raw_dvd <= bus.dividend;
                        cnt     <= '0;
                        prem    <= '0;
                        state   <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    prem <= r_next;
                    dsr  <= q_next;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'(DIV_ITER - 1)) begin
                        state  <= DIV_DONE;
                        done_r <= 1'b1;
                        quo_r  <= q_fix;
                        rem_r  <= r_fix;
                    end
                end
                DIV_DONE: begin
                    done_r <= 1'b0;
                    state  <= DIV_IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    state  <= DIV_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != DIV_IDLE);
    assign bus.done      = done_r;
    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
    assign dbg_state     = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected {quotient, remainder} pairs are queued
// at issue and popped when done pulses.
module tb_div_unit;
    import div_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    div_state_e dbg_state;

    div_unit_if bus();

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic score(input string tag);
        logic [63:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, " result"}, {bus.quotient, bus.remainder}, e);
    endtask

    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sd) begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            return {32'(q), 32'(r)};
        end
        return {a / b, a % b};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_start(input logic sd, input logic [31:0] a, input logic [31:0] b);
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.dividend   = a;
        bus.divisor    = b;
    endtask

    task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] res, input bit kill_done);
        int lat;
        int busy_n;
        @(negedge clk);
        drive_start(sd, a, b);
        exp_q.push_back(res);
        @(negedge clk);
        bus.start = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (bus.busy) busy_n++;
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " busy cycles"}, 64'(busy_n), 64'd33);
        score(tag);
        if (kill_done) bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check({tag, " done/busy after"}, {bus.done, bus.busy}, 64'b00);
        check({tag, " held"}, {bus.quotient, bus.remainder}, res);
        last_res = res;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        sd;
        logic [31:0] a, b;
        int          t, dones, lat;
        logic        prev;
        int          rise_t[$];

        rst = 1'b1;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset quotient", bus.quotient, 0);
        check("reset remainder", bus.remainder, 0);
        check("reset state", dbg_state, DIV_IDLE);

        run_op("divu ffffffff/16", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0FFF_FFFF, 32'hF}, 1'b0);
        run_op("div -7/2",  1'b1, 32'hFFFF_FFF9, 32'd2,          {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 1'b0);
        run_op("div 7/-2",  1'b1, 32'd7,         32'hFFFF_FFFE,  {32'hFFFF_FFFD, 32'h1}, 1'b0);
        run_op("div -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  {32'h3, 32'hFFFF_FFFF}, 1'b0);
        run_op("div 7/2",   1'b1, 32'd7,         32'd2,          {32'h3, 32'h1}, 1'b0);
        run_op("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 1'b0);
        run_op("divu 5/0",  1'b0, 32'd5,         32'd0,          {32'hFFFF_FFFF, 32'd5}, 1'b0);
        run_op("div -5/0",  1'b1, 32'hFFFF_FFFB, 32'd0,          {32'hFFFF_FFFF, 32'hFFFF_FFFB}, 1'b0);

        for (int i = 0; i < 4; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = 32'($urandom_range(2, 5000));
            if (sd && $urandom_range(0, 1) == 1) b = ~b + 32'd1;
            run_op("random", sd, a, b, model(sd, a, b), 1'b0);
        end

        // cancel at CALC iteration 10
        @(negedge clk);
        drive_start(1'b0, 32'd1000, 32'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel busy", bus.busy, 0);
        check("cancel done", bus.done, 0);
        check("cancel state", dbg_state, DIV_IDLE);
        check("cancel keeps outputs", {bus.quotient, bus.remainder}, last_res);
        run_op("after cancel", 1'b0, 32'd1000, 32'd7, model(1'b0, 32'd1000, 32'd7), 1'b0);

        // cancel in IDLE suppresses a same-cycle start
        @(negedge clk);
        drive_start(1'b0, 32'd9, 32'd3);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("idle cancel blocks start", bus.busy, 0);

        // cancel during DONE: outputs stay valid
        run_op("cancel in done", 1'b1, 32'hFFFF_FF00, 32'd3, model(1'b1, 32'hFFFF_FF00, 32'd3), 1'b1);

        // start held high: accepts every 34 cycles
        @(negedge clk);
        drive_start(1'b1, 32'hFFFF_FF9C, 32'd7);
        t = 0;
        dones = 0;
        prev = 1'b0;
        while (dones < 3 && t < 150) begin
            if (bus.busy === 1'b0 && bus.start) exp_q.push_back(model(1'b1, 32'hFFFF_FF9C, 32'd7));
            if (bus.busy && !prev) rise_t.push_back(t);
            if (bus.done) begin
                score("held start");
                dones++;
            end
            prev = bus.busy;
            if (dones < 3) begin
                @(negedge clk);
                t++;
            end
        end
        bus.start = 1'b0;
        check("held start dones", 64'(dones), 64'd3);
        check("held start accepts", 64'(rise_t.size()), 64'd3);
        for (int i = 1; i < rise_t.size(); i++)
            check("held start spacing", 64'(rise_t[i] - rise_t[i-1]), 64'd34);
        last_res = model(1'b1, 32'hFFFF_FF9C, 32'd7);
        @(negedge clk);

        // starts during CALC and DONE are ignored
        @(negedge clk);
        drive_start(1'b0, 32'd1000, 32'd3);
        exp_q.push_back({32'd333, 32'd1});
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat == 5 || lat == 20) drive_start(1'b1, 32'h0000_DEAD, 32'd5);
            else bus.start = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("ignored starts latency", 64'(lat), 64'd33);
        score("ignored starts");
        drive_start(1'b0, 32'd77, 32'd5);
        @(negedge clk);
        bus.start = 1'b0;
        check("start in done ignored", bus.busy, 0);
        check("start in done outputs", {bus.quotient, bus.remainder}, {32'd333, 32'd1});

        // reset mid-CALC clears everything
        @(negedge clk);
        drive_start(1'b0, 32'd50, 32'd3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst calc busy", bus.busy, 0);
        check("rst calc done", bus.done, 0);
        check("rst calc outputs", {bus.quotient, bus.remainder}, 64'd0);
        check("rst calc state", dbg_state, DIV_IDLE);

        // ---------------- report ----------------
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
